vreduction_wb_buffer: RTL and testbench

Downstream stage of the vector reduction unit. It pairs each reduction result with the destination register tag captured at issue. It then re-positions the scalar result into a full-width vector with a write mask, and queues results for register-file writeback over a valid/ready handshake. Because the reduction unit has no backpressure, the block issues credits so issue logic never launches more reductions than the buffer can absorb.

---
 rtl/vreduction_wb_buffer_if.sv | 44 ++++
 rtl/vreduction_wb_buffer.sv | 154 +++++++++++++++
 tb/tb_vreduction_wb_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vreduction_wb_buffer_if.sv
// Bundle of the issue, reducer-result and register-file writeback signals of the
// vector reduction writeback buffer, plus its status outputs.
interface vreduction_wb_buffer_if #(
    parameter int ELEMS = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  issue_valid;
    logic [TAGW-1:0]       issue_vd;
    logic                  issue_broadcast;
    logic [4:0]            issue_imm;
    logic                  issue_ready;
    logic                  red_valid;
    logic [ELEMS*16-1:0]   red_vector;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [TAGW-1:0]       wb_vd;
    logic [ELEMS*16-1:0]   wb_data;
    logic [ELEMS-1:0]      wb_mask;
    logic [CW-1:0]         outstanding;
    logic                  err_overflow;
    logic                  err_orphan;

    // Handshakes: issue is taken on a rising edge where issue_valid && issue_ready;
    // a writeback transfers on a rising edge where wb_valid && wb_ready, and wb_vd,
    // wb_data and wb_mask hold stable while wb_valid && !wb_ready. red_valid has no
    // ready: the credit (issue_ready) guarantees it can always be absorbed.
    modport slave (
        input  flush, issue_valid, issue_vd, issue_broadcast, issue_imm,
        input  red_valid, red_vector, wb_ready,
        output issue_ready, wb_valid, wb_vd, wb_data, wb_mask,
        output outstanding, err_overflow, err_orphan
    );

    modport master (
        output flush, issue_valid, issue_vd, issue_broadcast, issue_imm,
        output red_valid, red_vector, wb_ready,
        input  issue_ready, wb_valid, wb_vd, wb_data, wb_mask,
        input  outstanding, err_overflow, err_orphan
    );
endinterface

// File: rtl/vreduction_wb_buffer.sv
// Pairs reduction results with their issue-time destination tags, places the scalar
// into a masked full-width vector and queues it for register-file writeback.
module vreduction_wb_buffer #(
    parameter int ELEMS = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic                  CLK,
    input  logic                  nRST,
    vreduction_wb_buffer_if.slave bus
);
    localparam int W  = ELEMS * 16;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAGW-1:0]  tag_vd   [DEPTH];
    logic             tag_bc   [DEPTH];
    logic [4:0]       tag_imm  [DEPTH];
    logic [PW-1:0]    tag_rd, tag_wr;
    logic [CW-1:0]    tag_cnt;

    logic [TAGW-1:0]  res_vd   [DEPTH];
    logic [W-1:0]     res_data [DEPTH];
    logic [ELEMS-1:0] res_mask [DEPTH];
    logic [PW-1:0]    res_rd, res_wr;
    logic [CW-1:0]    res_cnt;

    logic [CW-1:0]    outstanding_q;
    logic             wb_valid_q;
    logic [TAGW-1:0]  wb_vd_q;
    logic [W-1:0]     wb_data_q;
    logic [ELEMS-1:0] wb_mask_q;
    logic             err_overflow_q;
    logic             err_orphan_q;

    logic             issue_ready;
    logic             issue_acc;
    logic             red_acc;
    logic             orphan;
    logic             wb_fire;
    logic             out_load;
    logic             res_pop;
    logic [W-1:0]     new_data;
    logic [ELEMS-1:0] new_mask;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Credit is taken from the registered count only, so a launch never depends
    // on what the reducer or the register file does in the same cycle.
    always_comb begin
        issue_ready = (outstanding_q < CW'(DEPTH));
        issue_acc   = bus.issue_valid && issue_ready;
        red_acc     = bus.red_valid && (tag_cnt != '0);
        orphan      = bus.red_valid && (tag_cnt == '0);
        wb_fire     = wb_valid_q && bus.wb_ready;
        out_load    = !wb_valid_q || bus.wb_ready;
        res_pop     = out_load && (res_cnt != '0);
    end

    // An out-of-range imm matches no element, leaving a zero mask and zero data.
    always_comb begin
        new_data = '0;
        new_mask = '0;
        for (int e = 0; e < ELEMS; e++) begin
            if (tag_bc[tag_rd]) begin
                new_mask[e]          = 1'b1;
                new_data[e*16 +: 16] = bus.red_vector[e*16 +: 16];
            end else if (int'(tag_imm[tag_rd]) == e) begin
                new_mask[e]          = 1'b1;
                new_data[e*16 +: 16] = bus.red_vector[15:0];
            end
        end
    end

    // Storage writes are harmless during flush/reset since the pointers restart.
    always_ff @(posedge CLK) begin
        if (issue_acc) begin
            tag_vd[tag_wr]  <= bus.issue_vd;
            tag_bc[tag_wr]  <= bus.issue_broadcast;
            tag_imm[tag_wr] <= bus.issue_imm;
        end
        if (red_acc) begin
            res_vd[res_wr]   <= tag_vd[tag_rd];
            res_data[res_wr] <= new_data;
            res_mask[res_wr] <= new_mask;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            tag_rd         <= '0;
            tag_wr         <= '0;
            tag_cnt        <= '0;
            res_rd         <= '0;
            res_wr         <= '0;
            res_cnt        <= '0;
            outstanding_q  <= '0;
            wb_valid_q     <= 1'b0;
            wb_vd_q        <= '0;
            wb_data_q      <= '0;
            wb_mask_q      <= '0;
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else if (bus.flush) begin
            tag_rd        <= '0;
            tag_wr        <= '0;
            tag_cnt       <= '0;
            res_rd        <= '0;
            res_wr        <= '0;
            res_cnt       <= '0;
            outstanding_q <= '0;
            wb_valid_q    <= 1'b0;
            wb_mask_q     <= '0;
        end else begin
            if (issue_acc) tag_wr <= ptr_inc(tag_wr);
            if (red_acc)   tag_rd <= ptr_inc(tag_rd);
            tag_cnt <= tag_cnt + CW'(issue_acc) - CW'(red_acc);

            if (red_acc) res_wr <= ptr_inc(res_wr);
            if (res_pop) res_rd <= ptr_inc(res_rd);
            res_cnt <= res_cnt + CW'(red_acc) - CW'(res_pop);

            // Output register is refilled from the stored head before this
            // cycle's result lands, giving one cycle from result to wb_valid.
            if (out_load) begin
                wb_valid_q <= (res_cnt != '0);
                if (res_cnt != '0) begin
                    wb_vd_q   <= res_vd[res_rd];
                    wb_data_q <= res_data[res_rd];
                    wb_mask_q <= res_mask[res_rd];
                end else begin
                    wb_mask_q <= '0;
                end
            end

            outstanding_q <= outstanding_q + CW'(issue_acc) - CW'(wb_fire);

            if (bus.issue_valid && !issue_ready) err_overflow_q <= 1'b1;
            if (orphan)                          err_orphan_q   <= 1'b1;
        end
    end

    assign bus.issue_ready  = issue_ready;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_vd        = wb_vd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_mask      = wb_mask_q;
    assign bus.outstanding  = outstanding_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_vreduction_wb_buffer.sv
// Directed bench for vreduction_wb_buffer: queue-based reference model compared every
// cycle, plus hand-computed expectations for each scenario.
module tb_vreduction_wb_buffer;
    localparam int ELEMS = 32;
    localparam int DEPTH = 4;
    localparam int TAGW  = 5;
    localparam int W     = ELEMS * 16;

    typedef struct {
        logic [TAGW-1:0] vd;
        logic            bc;
        logic [4:0]      imm;
    } tag_t;

    typedef struct {
        logic [TAGW-1:0]  vd;
        logic [W-1:0]     data;
        logic [ELEMS-1:0] mask;
    } res_t;

    logic clk;
    logic nrst;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 0;

    tag_t            tag_q[$];
    res_t            res_q[$];
    res_t            m_out;
    bit              m_out_valid = 0;
    bit              m_ovf = 0;
    bit              m_orph = 0;
    logic [TAGW-1:0] seen_q[$];
    logic [W-1:0]    exp_d;
    logic [W-1:0]    held_d;

    vreduction_wb_buffer_if #(.ELEMS(ELEMS), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();

    vreduction_wb_buffer #(.ELEMS(ELEMS), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush           = 1'b0;
        bus.issue_valid     = 1'b0;
        bus.issue_vd        = '0;
        bus.issue_broadcast = 1'b0;
        bus.issue_imm       = '0;
        bus.red_valid       = 1'b0;
    endtask

    task automatic issue(input int vd, input bit bc, input int imm);
        bus.issue_valid     = 1'b1;
        bus.issue_vd        = TAGW'(vd);
        bus.issue_broadcast = bc;
        bus.issue_imm       = 5'(imm);
    endtask

    task automatic result(input logic [15:0] e0, input logic [15:0] rest);
        bus.red_valid = 1'b1;
        for (int e = 0; e < ELEMS; e++) bus.red_vector[e*16 +: 16] = rest;
        bus.red_vector[15:0] = e0;
    endtask

    // Reference model: tags and results as plain queues, one output slot.
    always @(posedge clk) begin
        tag_t t;
        res_t r;
        bit   have_r;
        int   o;
        have_r = 0;
        if (!nrst) begin
            tag_q.delete();
            res_q.delete();
            m_out_valid = 0;
            m_ovf = 0;
            m_orph = 0;
        end else if (bus.flush) begin
            tag_q.delete();
            res_q.delete();
            m_out_valid = 0;
        end else begin
            o = tag_q.size() + res_q.size() + int'(m_out_valid);
            if (bus.issue_valid && o >= DEPTH) m_ovf = 1;
            if (bus.red_valid) begin
                if (tag_q.size() == 0) m_orph = 1;
                else begin
                    t = tag_q.pop_front();
                    r.vd = t.vd;
                    if (t.bc) begin
                        r.data = bus.red_vector;
                        r.mask = '1;
                    end else if (int'(t.imm) < ELEMS) begin
                        r.data = W'(bus.red_vector[15:0]) << (16 * int'(t.imm));
                        r.mask = ELEMS'(1) << t.imm;
                    end else begin
                        r.data = '0;
                        r.mask = '0;
                    end
                    have_r = 1;
                end
            end
            if (!m_out_valid || bus.wb_ready) begin
                if (res_q.size() > 0) begin
                    m_out = res_q.pop_front();
                    m_out_valid = 1;
                end else begin
                    m_out_valid = 0;
                end
            end
            if (have_r) res_q.push_back(r);
            if (bus.issue_valid && o < DEPTH) begin
                t.vd = bus.issue_vd;
                t.bc = bus.issue_broadcast;
                t.imm = bus.issue_imm;
                tag_q.push_back(t);
            end
        end
    end

    always @(negedge clk) begin
        int o;
        if (chk_en) begin
            o = tag_q.size() + res_q.size() + int'(m_out_valid);
            check("outstanding", W'(bus.outstanding), W'(o));
            check("issue_ready", W'(bus.issue_ready), W'(o < DEPTH));
            check("err_overflow", W'(bus.err_overflow), W'(m_ovf));
            check("err_orphan", W'(bus.err_orphan), W'(m_orph));
            check("wb_valid", W'(bus.wb_valid), W'(m_out_valid));
            if (m_out_valid) begin
                check("wb_vd", W'(bus.wb_vd), W'(m_out.vd));
                check("wb_data", bus.wb_data, m_out.data);
                check("wb_mask", W'(bus.wb_mask), W'(m_out.mask));
            end else begin
                check("wb_mask_idle", W'(bus.wb_mask), W'(0));
            end
            if (bus.wb_valid && bus.wb_ready) seen_q.push_back(bus.wb_vd);
        end
    end

    initial begin
        nrst = 1'b0;
        bus.wb_ready = 1'b0;
        bus.red_vector = '0;
        idle();
        tick();
        chk_en = 1;
        tick();
        check("rst_outstanding", W'(bus.outstanding), W'(0));
        check("rst_issue_ready", W'(bus.issue_ready), W'(1));
        check("rst_wb_valid", W'(bus.wb_valid), W'(0));
        check("rst_wb_vd", W'(bus.wb_vd), W'(0));
        check("rst_wb_data", bus.wb_data, W'(0));
        check("rst_wb_mask", W'(bus.wb_mask), W'(0));
        check("rst_errs", W'({bus.err_overflow, bus.err_orphan}), W'(0));
        nrst = 1'b1;
        tick();

        // Single non-broadcast result lands on element 7.
        issue(3, 0, 7);
        tick();
        idle();
        tick();
        result(16'h3C00, 16'h1111);
        tick();
        idle();
        check("t1_latency_low", W'(bus.wb_valid), W'(0));
        tick();
        exp_d = '0;
        exp_d[7*16 +: 16] = 16'h3C00;
        check("t1_wb_valid", W'(bus.wb_valid), W'(1));
        check("t1_wb_vd", W'(bus.wb_vd), W'(3));
        check("t1_wb_mask", W'(bus.wb_mask), W'(32'h0000_0080));
        check("t1_wb_data", bus.wb_data, exp_d);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        check("t1_drained", W'(bus.outstanding), W'(0));

        // Broadcast held under backpressure.
        issue(9, 1, 0);
        tick();
        idle();
        tick();
        result(16'h4000, 16'h4000);
        tick();
        idle();
        tick();
        held_d = {ELEMS{16'h4000}};
        for (int k = 0; k < 3; k++) begin
            check("t2_wb_valid", W'(bus.wb_valid), W'(1));
            check("t2_wb_vd", W'(bus.wb_vd), W'(9));
            check("t2_wb_mask", W'(bus.wb_mask), W'(32'hFFFF_FFFF));
            check("t2_wb_data", bus.wb_data, held_d);
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        check("t2_outstanding", W'(bus.outstanding), W'(0));
        check("t2_wb_valid_off", W'(bus.wb_valid), W'(0));

        // Credit limit and overflow.
        for (int i = 1; i <= 4; i++) begin
            issue(i, 0, i);
            tick();
        end
        idle();
        check("t3_issue_ready", W'(bus.issue_ready), W'(0));
        check("t3_outstanding", W'(bus.outstanding), W'(4));
        issue(5, 0, 0);
        tick();
        idle();
        check("t3_overflow", W'(bus.err_overflow), W'(1));
        check("t3_outstanding2", W'(bus.outstanding), W'(4));
        seen_q.delete();
        for (int i = 1; i <= 4; i++) begin
            result(16'h0100 + 16'(i), 16'h0);
            tick();
        end
        idle();
        bus.wb_ready = 1'b1;
        repeat (8) tick();
        bus.wb_ready = 1'b0;
        check("t3_seen_count", W'(seen_q.size()), W'(4));
        for (int i = 0; i < 4; i++)
            if (i < seen_q.size()) check("t3_order", W'(seen_q[i]), W'(i + 1));
        check("t3_issue_ready_back", W'(bus.issue_ready), W'(1));

        // Steady throughput: issue, result and writeback every cycle.
        seen_q.delete();
        for (int i = 10; i <= 12; i++) begin
            issue(i, 0, i);
            tick();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            result(16'h2000 + 16'(i), 16'h0);
            tick();
        end
        idle();
        tick();
        for (int k = 0; k < 8; k++) begin
            issue(13 + k, (k % 3) == 0, k);
            result(16'h3000 + 16'(k), 16'h5555);
            bus.wb_ready = 1'b1;
            tick();
            check("t4_steady", W'(bus.outstanding), W'(3));
        end
        idle();
        result(16'h3F00, 16'h0);
        tick();
        idle();
        repeat (8) tick();
        bus.wb_ready = 1'b0;
        check("t4_seen_count", W'(seen_q.size()), W'(11));
        for (int i = 0; i < 11; i++)
            if (i < seen_q.size()) check("t4_order", W'(seen_q[i]), W'(10 + i));

        // Orphan result.
        check("t5_no_orphan_yet", W'(bus.err_orphan), W'(0));
        result(16'h1234, 16'h0);
        tick();
        idle();
        check("t5_orphan", W'(bus.err_orphan), W'(1));
        check("t5_wb_valid", W'(bus.wb_valid), W'(0));
        check("t5_outstanding", W'(bus.outstanding), W'(0));

        // Reset mid-operation clears errors too.
        issue(7, 0, 1);
        tick();
        idle();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("rst2_outstanding", W'(bus.outstanding), W'(0));
        check("rst2_errs", W'({bus.err_overflow, bus.err_orphan}), W'(0));

        // Flush mid-stream with concurrent traffic.
        for (int i = 20; i <= 22; i++) begin
            issue(i, 0, 2);
            tick();
        end
        idle();
        result(16'h0AAA, 16'h0);
        tick();
        idle();
        tick();
        check("t6_pre_outstanding", W'(bus.outstanding), W'(3));
        bus.flush = 1'b1;
        issue(23, 0, 0);
        result(16'h0BBB, 16'h0);
        bus.wb_ready = 1'b1;
        tick();
        idle();
        bus.wb_ready = 1'b0;
        check("t6_outstanding", W'(bus.outstanding), W'(0));
        check("t6_wb_valid", W'(bus.wb_valid), W'(0));
        check("t6_no_orphan", W'(bus.err_orphan), W'(0));
        result(16'h0CCC, 16'h0);
        tick();
        idle();
        check("t6_orphan", W'(bus.err_orphan), W'(1));
        check("t6_wb_valid_after", W'(bus.wb_valid), W'(0));

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
